// File: rtl/fully_connected_mac.sv
// rtl/fully_connected_mac.sv - sequential multi-neuron fully-connected MAC stage (optional FC_SATURATE_EN: saturating accumulators)
module fully_connected_mac #(
    parameter int FLATTENED_LENGTH          = 50,
    parameter int NUM_OUTPUTS               = 4,
    parameter int CONVOLUTION_DATA_WIDTH    = 8,
    parameter int FULLYCONNECTED_DATA_WIDTH = 8,
    parameter int OUTPUT_DATA_WIDTH         = 32,
    localparam int IDX_W = $clog2(FLATTENED_LENGTH + 1)
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           fullyconnect_start,
    input  logic                                           in_valid,
    input  logic [CONVOLUTION_DATA_WIDTH-1:0]              in_data,
    output logic                                           in_ready,
    input  logic [NUM_OUTPUTS*FULLYCONNECTED_DATA_WIDTH-1:0] fullyconnected_weights,
    output logic [IDX_W-1:0]                               weight_index,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [NUM_OUTPUTS*OUTPUT_DATA_WIDTH-1:0]       fullyconnected_output,
    output logic                                           busy
);

    localparam int CW = CONVOLUTION_DATA_WIDTH;
    localparam int FW = FULLYCONNECTED_DATA_WIDTH;
    localparam int OW = OUTPUT_DATA_WIDTH;
    localparam int PW = CW + FW;
    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(FLATTENED_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic start_accepted;
    logic beat;
    logic last_beat;

    // Start is only honoured in IDLE; beats only count while accumulating.
    assign start_accepted = (state == IDLE) && fullyconnect_start;
    assign beat           = (state == ACCUM) && in_valid;
    assign last_beat      = beat && (weight_index == LAST_INDEX);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fullyconnect_start) state_next = ACCUM;
            ACCUM:   if (last_beat)          state_next = DONE;
            DONE:    if (out_ready)          state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the registered state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Element index: addresses the external weight store, wraps after the last beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weight_index <= '0;
        end else if (start_accepted || last_beat) begin
            weight_index <= '0;
        end else if (beat) begin
            weight_index <= weight_index + IDX_W'(1);
        end
    end

    for (genvar n = 0; n < NUM_OUTPUTS; n++) begin : g_neuron
        logic [PW-1:0] product;
        logic [OW-1:0] product_ext;
        logic [OW-1:0] acc_sum;
        logic [OW-1:0] acc;

        assign product     = PW'(in_data) * PW'(fullyconnected_weights[n*FW +: FW]);
        assign product_ext = OW'(product);

`ifdef FC_SATURATE_EN
        logic [OW:0] wide_sum;

        // Carry out of the accumulator width pins the sum at full scale; a pinned
        // accumulator stays pinned because every later addend is non-negative.
        assign wide_sum = {1'b0, acc} + {1'b0, product_ext};
        assign acc_sum  = wide_sum[OW] ? {OW{1'b1}} : wide_sum[OW-1:0];
`else
        assign acc_sum = acc + product_ext;
`endif

        // Accumulator: cleared on start, updated per accepted beat, held otherwise
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                acc <= '0;
            end else if (start_accepted) begin
                acc <= '0;
            end else if (beat) begin
                acc <= acc_sum;
            end
        end

        assign fullyconnected_output[n*OW +: OW] = acc;
    end

endmodule

// File: tb/tb_fully_connected_mac.sv
// tb/tb_fully_connected_mac.sv - self-checking bench for fully_connected_mac
module tb_fully_connected_mac;

    localparam int FL = 50;
    localparam int NO = 4;
    localparam int OW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Default-parameter instance
    logic              start, in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]        in_data;
    logic [NO*8-1:0]   weights;
    logic [5:0]        weight_index;
    logic [NO*OW-1:0]  fc_out;

    // 16-bit accumulator instance, one neuron
    logic        start16, valid16, ready16, ovalid16, oready16, busy16;
    logic [7:0]  data16, weights16;
    logic [5:0]  index16;
    logic [15:0] out16;

    // Single-element instance, one neuron
    logic        start1, valid1, ready1, ovalid1, oready1, busy1;
    logic [7:0]  data1, weights1;
    logic [0:0]  index1;
    logic [31:0] out1;

    int checks = 0;
    int errors = 0;
    int cur_wmode = 0;
    int cur_wval  = 0;

    fully_connected_mac dut (
        .clk(clk), .reset(reset), .fullyconnect_start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fullyconnected_weights(weights), .weight_index(weight_index),
        .out_valid(out_valid), .out_ready(out_ready),
        .fullyconnected_output(fc_out), .busy(busy)
    );

    fully_connected_mac #(.NUM_OUTPUTS(1), .OUTPUT_DATA_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .fullyconnect_start(start16),
        .in_valid(valid16), .in_data(data16), .in_ready(ready16),
        .fullyconnected_weights(weights16), .weight_index(index16),
        .out_valid(ovalid16), .out_ready(oready16),
        .fullyconnected_output(out16), .busy(busy16)
    );

    fully_connected_mac #(.FLATTENED_LENGTH(1), .NUM_OUTPUTS(1)) dut1 (
        .clk(clk), .reset(reset), .fullyconnect_start(start1),
        .in_valid(valid1), .in_data(data1), .in_ready(ready1),
        .fullyconnected_weights(weights1), .weight_index(index1),
        .out_valid(ovalid1), .out_ready(oready1),
        .fullyconnected_output(out1), .busy(busy1)
    );

    // Weight store model: 0 = constant, 1 = constant*(neuron+1), 2 = element index
    function automatic logic [7:0] wfun(input int mode, input int val, input int n, input int idx);
        case (mode)
            0:       return 8'(val);
            1:       return 8'(val * (n + 1));
            default: return 8'(idx);
        endcase
    endfunction

    always_comb begin
        weights = '0;
        for (int n = 0; n < NO; n++) begin
            weights[n*8 +: 8] = wfun(cur_wmode, cur_wval, n, int'(weight_index));
        end
    end

    typedef struct {
        bit           ramp;   // data = i+1 when set, else dval
        int           dval;
        int           wmode;
        int           wval;
        bit           gaps;   // idle cycle before every beat
        int           bp;     // cycles of out_ready=0 in DONE
        logic [127:0] exp;    // {n3, n2, n1, n0}
    } vec_t;

    vec_t vecs [5];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [127:0] model;
        logic [7:0]   d;
        model     = '0;
        cur_wmode = v.wmode;
        cur_wval  = v.wval;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("acc_clear", fc_out, 0);
        for (int i = 0; i < FL; i++) begin
            if (v.gaps) begin
                in_valid = 1'b0;
                in_data  = 8'hAA;
                tick();
                check("gap_ready", in_ready, 1);
                check("gap_hold", fc_out, model);
            end
            d        = v.ramp ? 8'(i + 1) : 8'(v.dval);
            in_valid = 1'b1;
            in_data  = d;
            check("index", weight_index, i);
            check("valid_early", out_valid, 0);
            for (int n = 0; n < NO; n++) begin
                model[n*32 +: 32] = model[n*32 +: 32] + 32'(d) * 32'(wfun(v.wmode, v.wval, n, i));
            end
            tick();
        end
        in_valid = 1'b0;
        check("out_valid_latency", out_valid, 1);
        check("ready_in_done", in_ready, 0);
        check("index_wrap", weight_index, 0);
        check("result", fc_out, v.exp);
        for (int b = 0; b < v.bp; b++) begin
            out_ready = 1'b0;
            start     = (b == 2);
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_hold", fc_out, v.exp);
        end
        start     = (v.bp > 0);
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        check("idle_after_handshake", busy, 0);
        check("out_valid_drop", out_valid, 0);
        check("out_retained", fc_out, v.exp);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        tick();
        in_valid = 1'b0;
        check("idle_ready", in_ready, 0);
        check("idle_ignores_valid", fc_out, v.exp);
    endtask

    initial begin
        logic [15:0] exp16;

        vecs[0] = '{1'b1, 0,   0, 2, 1'b0, 0, {4{32'd2550}}};
        vecs[1] = '{1'b0, 3,   1, 1, 1'b1, 0, {32'd600, 32'd450, 32'd300, 32'd150}};
        vecs[2] = '{1'b0, 1,   2, 0, 1'b0, 5, {4{32'd1225}}};
        vecs[3] = '{1'b0, 255, 1, 1, 1'b0, 0, {32'd51000, 32'd38250, 32'd25500, 32'd12750}};
        vecs[4] = '{1'b0, 1,   0, 1, 1'b0, 0, {4{32'd50}}};

        reset = 1'b1;
        start = 0; in_valid = 0; in_data = 0; out_ready = 0;
        start16 = 0; valid16 = 0; data16 = 0; weights16 = 0; oready16 = 0;
        start1 = 0; valid1 = 0; data1 = 0; weights1 = 0; oready1 = 0;
        tick();
        tick();
        check("reset_ready", in_ready, 0);
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_index", weight_index, 0);
        check("reset_out", fc_out, 0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) begin
            run_vec(vecs[k]);
        end

        // Reset in the middle of accumulation aborts the run
        cur_wmode = 0;
        cur_wval  = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd1;
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_acc", fc_out, {4{32'd20}});
        #2 reset = 1'b1;
        #1;
        check("async_rst_out", fc_out, 0);
        check("async_rst_ready", in_ready, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_index", weight_index, 0);
        check("async_rst_valid", out_valid, 0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_idle", busy, 0);
        run_vec(vecs[4]);

        // 16-bit accumulator overflow: 50 * 255 * 255 = 3251250
`ifdef FC_SATURATE_EN
        exp16 = 16'd65535;
`else
        exp16 = 16'd39986;    // 3251250 mod 65536
`endif
        weights16 = 8'd255;
        start16   = 1'b1;
        tick();
        start16 = 1'b0;
        for (int i = 0; i < FL; i++) begin
            valid16 = 1'b1;
            data16  = 8'd255;
            tick();
        end
        valid16 = 1'b0;
        check("ow16_valid", ovalid16, 1);
        check("ow16_result", out16, exp16);
        oready16 = 1'b1;
        tick();
        oready16 = 1'b0;
        check("ow16_idle", busy16, 0);

        // Single-element inference
        weights1 = 8'd9;
        valid1   = 1'b1;
        data1    = 8'd5;
        tick();
        tick();
        check("fl1_pre_start_ready", ready1, 0);
        check("fl1_pre_start_busy", busy1, 0);
        check("fl1_pre_start_out", out1, 0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("fl1_accum_ready", ready1, 1);
        data1 = 8'd7;
        check("fl1_index", index1, 0);
        tick();
        check("fl1_valid", ovalid1, 1);
        check("fl1_result", out1, 63);
        check("fl1_done_ready", ready1, 0);
        data1 = 8'd100;
        tick();
        tick();
        check("fl1_done_hold", out1, 63);
        check("fl1_done_valid", ovalid1, 1);
        oready1 = 1'b1;
        tick();
        oready1 = 1'b0;
        valid1  = 1'b0;
        check("fl1_idle_valid", ovalid1, 0);
        check("fl1_idle_busy", busy1, 0);
        check("fl1_retained", out1, 63);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
